// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Checks a light controller's phase sequence, drives lamps and latches faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
    parameter int MAX_DWELL = 8,
    parameter int FLASH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light,
    input  logic       clear_fault,
    output logic       lamp_r,
    output logic       lamp_g,
    output logic       lamp_y,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] cycle_count
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] C_RED     = 2'b00;
    localparam logic [1:0] C_GREEN   = 2'b01;
    localparam logic [1:0] C_YELLOW  = 2'b10;
    localparam logic [1:0] C_ILLEGAL = 2'b11;

    localparam logic [1:0] C_FC_CODE  = 2'b01;
    localparam logic [1:0] C_FC_TRANS = 2'b10;
    localparam logic [1:0] C_FC_STUCK = 2'b11;

    localparam logic [7:0] C_DWELL_LAST = 8'(MAX_DWELL - 1);
    localparam logic [7:0] C_FLASH_LAST = 8'(FLASH_DIV - 1);

    state_t     state;
    logic [1:0] prev;
    logic [7:0] dwell;
    logic [7:0] flash_cnt;

    logic       is_hold;
    logic       is_legal_step;
    logic [1:0] run_fault_code;

    assign is_hold = (light == prev);
    assign is_legal_step = ((prev == C_RED)    && (light == C_GREEN))  ||
                           ((prev == C_GREEN)  && (light == C_YELLOW)) ||
                           ((prev == C_YELLOW) && (light == C_RED));

    // Zero means the sample is acceptable; checks are listed in priority order.
    always_comb begin
        run_fault_code = 2'b00;
        if (light == C_ILLEGAL) begin
            run_fault_code = C_FC_CODE;
        end else if (!is_hold && !is_legal_step) begin
            run_fault_code = C_FC_TRANS;
        end else if (is_hold && (dwell == C_DWELL_LAST)) begin
            run_fault_code = C_FC_STUCK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_INIT;
            lamp_r      <= 1'b1;
            lamp_g      <= 1'b0;
            lamp_y      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
            cycle_count <= 8'd0;
            prev        <= C_RED;
            dwell       <= 8'd0;
            flash_cnt   <= 8'd0;
        end else begin
            case (state)
                S_INIT: begin
                    if (light == C_ILLEGAL) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= C_FC_CODE;
                        lamp_r     <= 1'b1;
                        lamp_g     <= 1'b0;
                        lamp_y     <= 1'b0;
                        flash_cnt  <= 8'd0;
                    end else begin
                        state  <= S_RUN;
                        prev   <= light;
                        dwell  <= 8'd1;
                        lamp_r <= (light == C_RED);
                        lamp_g <= (light == C_GREEN);
                        lamp_y <= (light == C_YELLOW);
                    end
                end

                S_RUN: begin
                    if (run_fault_code != 2'b00) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= run_fault_code;
                        lamp_r     <= 1'b1;
                        lamp_g     <= 1'b0;
                        lamp_y     <= 1'b0;
                        flash_cnt  <= 8'd0;
                    end else begin
                        lamp_r <= (light == C_RED);
                        lamp_g <= (light == C_GREEN);
                        lamp_y <= (light == C_YELLOW);
                        if (is_hold) begin
                            dwell <= dwell + 8'd1;
                        end else begin
                            prev  <= light;
                            dwell <= 8'd1;
                            if (prev == C_YELLOW) begin
                                cycle_count <= cycle_count + 8'd1;
                            end
                        end
                    end
                end

                S_FAULT: begin
                    if (clear_fault) begin
                        state      <= S_INIT;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                        lamp_r     <= 1'b1;
                        lamp_g     <= 1'b0;
                        lamp_y     <= 1'b0;
                        flash_cnt  <= 8'd0;
                    end else if (flash_cnt == C_FLASH_LAST) begin
                        lamp_r    <= ~lamp_r;
                        flash_cnt <= 8'd0;
                    end else begin
                        flash_cnt <= flash_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// Module   : tb_traffic_light_monitor
// Purpose  : Directed stimulus with a queue-based scoreboard for traffic_light_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] light;
    logic       clear_fault;
    logic       lamp_r, lamp_g, lamp_y, fault;
    logic [1:0] fault_code;
    logic [7:0] cycle_count;

    traffic_light_monitor #(.MAX_DWELL(8), .FLASH_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .light       (light),
        .clear_fault (clear_fault),
        .lamp_r      (lamp_r),
        .lamp_g      (lamp_g),
        .lamp_y      (lamp_y),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;
    localparam logic [2:0] N = 3'b000;

    typedef struct {
        logic [13:0] v;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    function automatic logic [13:0] observed();
        return {lamp_r, lamp_g, lamp_y, fault, fault_code, cycle_count};
    endfunction

    task automatic compare(input string name, input int id, input logic [13:0] exp);
        logic [13:0] act;
        act = observed();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: actual rgy=%b fault=%b code=%b count=%0d, required rgy=%b fault=%b code=%b count=%0d",
                     name, id, act[13:11], act[10], act[9:8], act[7:0],
                     exp[13:11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    // Drive one sample at the current falling edge, queue the response expected after the next rising edge.
    task automatic step(input logic [1:0] l, input logic clr, input logic [2:0] lamps,
                        input logic f, input logic [1:0] code, input logic [7:0] cnt);
        exp_t e;
        light       = l;
        clear_fault = clr;
        e.v  = {lamps, f, code, cnt};
        e.id = n_step;
        q.push_back(e);
        n_step++;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare("step", e.id, e.v);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        exp_t e;
        reset       = 1'b1;
        light       = 2'b00;
        clear_fault = 1'b0;
        @(negedge clk);
        compare("reset_state", 0, {R, 1'b0, 2'b00, 8'd0});
        reset = 1'b0;

        // Three full Red-Green-Yellow passes, then run the counter up to its wrap.
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, R, 1'b0, 2'b00, 8'(i));
            step(2'b01, 1'b0, G, 1'b0, 2'b00, 8'(i));
            step(2'b10, 1'b0, Y, 1'b0, 2'b00, 8'(i));
        end
        for (int k = 3; k < 256; k++) begin
            step(2'b00, 1'b0, R, 1'b0, 2'b00, 8'(k));
            step(2'b01, 1'b0, G, 1'b0, 2'b00, 8'(k));
            step(2'b10, 1'b0, Y, 1'b0, 2'b00, 8'(k));
        end
        step(2'b00, 1'b0, R, 1'b0, 2'b00, 8'd0);

        // Green held for 7 samples is legal; 8 samples is stuck.
        repeat (7) step(2'b01, 1'b0, G, 1'b0, 2'b00, 8'd0);
        step(2'b10, 1'b0, Y, 1'b0, 2'b00, 8'd0);
        step(2'b00, 1'b0, R, 1'b0, 2'b00, 8'd1);
        repeat (7) step(2'b01, 1'b0, G, 1'b0, 2'b00, 8'd1);
        step(2'b01, 1'b0, R, 1'b1, 2'b11, 8'd1);

        // Red flashes with a 4-cycle half period; light is ignored.
        for (int j = 1; j <= 8; j++) begin
            step((j % 2) ? 2'b11 : 2'b10, 1'b0, (((j / 4) % 2) == 0) ? R : N, 1'b1, 2'b11, 8'd1);
        end
        step(2'b01, 1'b1, R, 1'b0, 2'b00, 8'd1);

        // Illegal transition Red -> Yellow, then clear while lamp_r is dark.
        step(2'b00, 1'b0, R, 1'b0, 2'b00, 8'd1);
        step(2'b10, 1'b0, R, 1'b1, 2'b10, 8'd1);
        for (int j = 1; j <= 5; j++) begin
            step(2'b00, 1'b0, (j < 4) ? R : N, 1'b1, 2'b10, 8'd1);
        end
        step(2'b00, 1'b1, R, 1'b0, 2'b00, 8'd1);

        // Illegal code sampled in INIT.
        step(2'b11, 1'b0, R, 1'b1, 2'b01, 8'd1);
        step(2'b11, 1'b1, R, 1'b0, 2'b00, 8'd1);
        step(2'b00, 1'b0, R, 1'b0, 2'b00, 8'd1);

        // clear_fault has no effect in RUN; the first fault code sticks.
        step(2'b01, 1'b1, G, 1'b0, 2'b00, 8'd1);
        step(2'b00, 1'b1, R, 1'b1, 2'b10, 8'd1);
        for (int j = 1; j <= 4; j++) begin
            step(2'b11, 1'b0, (j < 4) ? R : N, 1'b1, 2'b10, 8'd1);
        end

        // Asynchronous reset while lamp_r is dark in FAULT.
        light       = 2'b00;
        clear_fault = 1'b0;
        reset       = 1'b1;
        #1;
        compare("async_reset", 1, {R, 1'b0, 2'b00, 8'd0});
        e.v  = {R, 1'b0, 2'b00, 8'd0};
        e.id = n_step;
        q.push_back(e);
        n_step++;
        @(negedge clk);
        reset = 1'b0;
        step(2'b10, 1'b0, Y, 1'b0, 2'b00, 8'd0);
        step(2'b00, 1'b0, R, 1'b0, 2'b00, 8'd1);

        for (int t = 0; t < 5 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: actual %0d pending, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
